// File: rtl/filter_pkg.sv
// ============================================================================
// filter_pkg: shared types and width helpers for sample_filter_bank
// Rev 1.0
// ============================================================================
`default_nettype none

package filter_pkg;

   typedef enum logic [1:0] {
      MODE_ZERO   = 2'd0,
      MODE_BYPASS = 2'd1,
      MODE_AVG    = 2'd2,
      MODE_IIR    = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READ   = 2'd1,
      ST_UPDATE = 2'd2,
      ST_OUT    = 2'd3
   } state_e;

   localparam int DEF_DATA_W    = 16;
   localparam int DEF_AVG_LOG2  = 3;
   localparam int DEF_IIR_SHIFT = 4;

   // Widths for the default configuration; parameterised instances use the functions.
   localparam int SUM_W = DEF_DATA_W + DEF_AVG_LOG2;
   localparam int ACC_W = DEF_DATA_W + DEF_IIR_SHIFT;

   function automatic int sum_width(input int data_w, input int avg_log2);
      return data_w + avg_log2;
   endfunction

   function automatic int acc_width(input int data_w, input int iir_shift);
      return data_w + iir_shift;
   endfunction

endpackage

`default_nettype wire

// File: rtl/avg_history.sv
// ============================================================================
// avg_history: per-channel circular sample buffers and running sums
// Rev 1.0
// ============================================================================
`default_nettype none

module avg_history
   import filter_pkg::*;
#(
   parameter int  DATA_W    = 16,
   parameter int  CHANNELS  = 2,
   parameter int  AVG_LOG2  = 3,
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int SUM_WIDTH = sum_width(DATA_W, AVG_LOG2)
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        clear_i,
   input  logic [CH_W-1:0]             rd_ch_i,
   output logic signed [DATA_W-1:0]    oldest_o,
   output logic signed [SUM_WIDTH-1:0] sum_o,
   input  logic                        wr_en_i,
   input  logic [CH_W-1:0]             wr_ch_i,
   input  logic signed [DATA_W-1:0]    wr_data_i,
   input  logic signed [SUM_WIDTH-1:0] wr_sum_i
);

   localparam int DEPTH = 2 ** AVG_LOG2;

   logic signed [DATA_W-1:0]    hist_q [CHANNELS][DEPTH];
   logic        [AVG_LOG2-1:0]  ptr_q  [CHANNELS];
   logic signed [SUM_WIDTH-1:0] sum_q  [CHANNELS];

   // The slot about to be overwritten is the oldest entry in the window.
   always_comb begin
      oldest_o = hist_q[rd_ch_i][ptr_q[rd_ch_i]];
      sum_o    = sum_q[rd_ch_i];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i || clear_i) begin
         for (int c = 0; c < CHANNELS; c++) begin
            for (int i = 0; i < DEPTH; i++) begin
               hist_q[c][i] <= '0;
            end
            ptr_q[c] <= '0;
            sum_q[c] <= '0;
         end
      end else if (wr_en_i) begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (wr_ch_i == CH_W'(c)) begin
               hist_q[c][ptr_q[c]] <= wr_data_i;
               ptr_q[c]            <= ptr_q[c] + AVG_LOG2'(1);
               sum_q[c]            <= wr_sum_i;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/sample_filter_bank.sv
// ============================================================================
// sample_filter_bank: multi-channel zero/bypass/moving-average/IIR filter
// Rev 1.0
// ============================================================================
`default_nettype none

module sample_filter_bank
   import filter_pkg::*;
#(
   parameter int  DATA_W    = 16,
   parameter int  CHANNELS  = 2,
   parameter int  AVG_LOG2  = 3,
   parameter int  IIR_SHIFT = 4,
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [CH_W-1:0]          ch_i,
   input  logic signed [DATA_W-1:0] data_i,
   input  logic [1:0]               mode_i,
   input  logic                     clear_i,
   output logic                     valid_o,
   output logic [CH_W-1:0]          ch_o,
   output logic signed [DATA_W-1:0] data_o,
   output logic                     overrun_o
);

   localparam int             SUM_WIDTH = sum_width(DATA_W, AVG_LOG2);
   localparam int             ACC_WIDTH = acc_width(DATA_W, IIR_SHIFT);
   localparam logic [CH_W:0]  NUM_CH    = (CH_W + 1)'(CHANNELS);

   state_e                      state_q, state_d;
   logic [CH_W-1:0]             ch_q;
   logic signed [DATA_W-1:0]    x_q;
   mode_e                       mode_q;
   logic signed [DATA_W-1:0]    oldest_q;
   logic signed [SUM_WIDTH-1:0] sum_rd_q;
   logic signed [ACC_WIDTH-1:0] acc_rd_q;
   logic signed [ACC_WIDTH-1:0] acc_q [CHANNELS];
   logic                        valid_q;
   logic [CH_W-1:0]             ch_out_q;
   logic signed [DATA_W-1:0]    data_out_q;
   logic                        overrun_q;

   logic                        ch_ok;
   logic                        accept;
   logic                        hist_wr;
   logic signed [DATA_W-1:0]    hist_oldest;
   logic signed [SUM_WIDTH-1:0] hist_sum;
   logic signed [SUM_WIDTH-1:0] sum_new;
   logic signed [ACC_WIDTH-1:0] acc_new;
   logic signed [DATA_W-1:0]    filt;

   avg_history #(
      .DATA_W   (DATA_W),
      .CHANNELS (CHANNELS),
      .AVG_LOG2 (AVG_LOG2)
   ) u_avg_history (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .clear_i   (clear_i),
      .rd_ch_i   (ch_q),
      .oldest_o  (hist_oldest),
      .sum_o     (hist_sum),
      .wr_en_i   (hist_wr),
      .wr_ch_i   (ch_q),
      .wr_data_i (x_q),
      .wr_sum_i  (sum_new)
   );

   always_comb begin
      state_d = state_q;
      ready_o = (state_q == ST_IDLE) && !reset_i;
      ch_ok   = ({1'b0, ch_i} < NUM_CH);
      accept  = valid_i && (state_q == ST_IDLE) && ch_ok && !clear_i;
      hist_wr = (state_q == ST_UPDATE) && !clear_i;
      case (state_q)
         ST_IDLE:   if (accept) state_d = ST_READ;
         ST_READ:   state_d = ST_UPDATE;
         ST_UPDATE: state_d = ST_OUT;
         ST_OUT:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if (clear_i) state_d = ST_IDLE;
   end

   // Result slices equal an arithmetic shift because SUM/ACC are exactly DATA_W+shift wide.
   always_comb begin
      sum_new = sum_rd_q + SUM_WIDTH'(x_q) - SUM_WIDTH'(oldest_q);
      acc_new = acc_rd_q + ACC_WIDTH'(x_q) - (acc_rd_q >>> IIR_SHIFT);
      filt    = '0;
      case (mode_q)
         MODE_ZERO:   filt = '0;
         MODE_BYPASS: filt = x_q;
         MODE_AVG:    filt = sum_new[AVG_LOG2 +: DATA_W];
         MODE_IIR:    filt = acc_new[IIR_SHIFT +: DATA_W];
         default:     filt = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         ch_q       <= '0;
         x_q        <= '0;
         mode_q     <= MODE_ZERO;
         oldest_q   <= '0;
         sum_rd_q   <= '0;
         acc_rd_q   <= '0;
         valid_q    <= 1'b0;
         ch_out_q   <= '0;
         data_out_q <= '0;
         overrun_q  <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= 1'b0;
         if (accept) begin
            ch_q   <= ch_i;
            x_q    <= data_i;
            mode_q <= mode_e'(mode_i);
         end
         if (clear_i) begin
            overrun_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
         end else begin
            if (valid_i && (state_q != ST_IDLE)) overrun_q <= 1'b1;
            case (state_q)
               ST_READ: begin
                  oldest_q <= hist_oldest;
                  sum_rd_q <= hist_sum;
                  acc_rd_q <= acc_q[ch_q];
               end
               ST_UPDATE: begin
                  acc_q[ch_q] <= acc_new;
                  valid_q     <= 1'b1;
                  ch_out_q    <= ch_q;
                  data_out_q  <= filt;
               end
               default: ;
            endcase
         end
      end
   end

   assign valid_o   = valid_q;
   assign ch_o      = ch_out_q;
   assign data_o    = data_out_q;
   assign overrun_o = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_sample_filter_bank.sv
// ============================================================================
// tb_sample_filter_bank: randomized and directed checks against a window/IIR model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sample_filter_bank;

   localparam int DATA_W   = 16;
   localparam int CHANNELS = 2;
   localparam int DEPTH    = 8;
   localparam int SHIFT    = 4;

   logic                     clk_i = 1'b0;
   logic                     reset_i = 1'b1;
   logic                     valid_i = 1'b0;
   logic                     ready_o;
   logic [0:0]               ch_i = '0;
   logic signed [DATA_W-1:0] data_i = '0;
   logic [1:0]               mode_i = '0;
   logic                     clear_i = 1'b0;
   logic                     valid_o;
   logic [0:0]               ch_o;
   logic signed [DATA_W-1:0] data_o;
   logic                     overrun_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: last DEPTH samples per channel and the IIR accumulator.
   int     win   [CHANNELS][DEPTH];
   int     wpos  [CHANNELS];
   longint acc_m [CHANNELS];

   sample_filter_bank #(
      .DATA_W    (DATA_W),
      .CHANNELS  (CHANNELS),
      .AVG_LOG2  (3),
      .IIR_SHIFT (SHIFT)
   ) dut (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .ch_i      (ch_i),
      .data_i    (data_i),
      .mode_i    (mode_i),
      .clear_i   (clear_i),
      .valid_o   (valid_o),
      .ch_o      (ch_o),
      .data_o    (data_o),
      .overrun_o (overrun_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint floor_div(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
      return q;
   endfunction

   function automatic void model_clear();
      for (int c = 0; c < CHANNELS; c++) begin
         for (int i = 0; i < DEPTH; i++) win[c][i] = 0;
         wpos[c]  = 0;
         acc_m[c] = 0;
      end
   endfunction

   function automatic longint model(input int ch, input int x, input int m);
      longint s;
      win[ch][wpos[ch]] = x;
      wpos[ch] = (wpos[ch] + 1) % DEPTH;
      s = 0;
      for (int i = 0; i < DEPTH; i++) s += win[ch][i];
      acc_m[ch] = acc_m[ch] + x - floor_div(acc_m[ch], 2 ** SHIFT);
      case (m)
         0:       return 0;
         1:       return x;
         2:       return floor_div(s, DEPTH);
         default: return floor_div(acc_m[ch], 2 ** SHIFT);
      endcase
   endfunction

   // Waits for ready, presents one sample and returns at the negedge of cycle n+1.
   task automatic drive(input int ch, input int d, input int m);
      int n = 0;
      while (!ready_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      if (!ready_o) chk("ready_wait", 0, 1);
      valid_i = 1'b1;
      ch_i    = ch[0:0];
      data_i  = d[DATA_W-1:0];
      mode_i  = m[1:0];
      @(negedge clk_i);
      valid_i = 1'b0;
   endtask

   task automatic collect(input string tag, input int ch, input longint exp, input int already);
      int n = already;
      while (!valid_o && n < 8) begin
         if (n == 1 || n == 2) chk({tag, "_busy"}, ready_o, 0);
         @(negedge clk_i);
         n++;
      end
      chk({tag, "_lat"}, n, 3);
      chk({tag, "_data"}, longint'(data_o), exp);
      chk({tag, "_ch"}, longint'(ch_o), ch);
      @(negedge clk_i);
      chk({tag, "_pulse"}, valid_o, 0);
   endtask

   task automatic send(input string tag, input int ch, input int d, input int m);
      longint exp;
      drive(ch, d, m);
      exp = model(ch, d, m);
      collect(tag, ch, exp, 1);
   endtask

   task automatic pulse_clear();
      @(negedge clk_i);
      clear_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
      model_clear();
   endtask

   task automatic count_pulses(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         if (valid_o) cnt++;
         @(negedge clk_i);
      end
   endtask

   initial begin
      int cnt;
      model_clear();

      repeat (3) @(negedge clk_i);
      chk("rst_ready", ready_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_data", longint'(data_o), 0);
      chk("rst_ch", longint'(ch_o), 0);
      chk("rst_ovr", overrun_o, 0);
      reset_i = 1'b0;
      @(negedge clk_i);
      chk("rel_ready", ready_o, 1);

      send("bypass", 0, 16'h1234, 1);

      pulse_clear();
      for (int k = 1; k <= 8; k++) send("avg", 0, 800, 2);
      chk("avg_final", longint'(data_o), 800);
      pulse_clear();
      send("avg_neg", 0, -8, 2);
      chk("avg_neg_val", longint'(data_o), -1);

      pulse_clear();
      send("iir1", 0, 1600, 3);
      chk("iir1_val", longint'(data_o), 100);
      send("iir2", 0, 1600, 3);
      chk("iir2_val", longint'(data_o), 193);
      send("iir3", 0, 1600, 3);
      chk("iir3_val", longint'(data_o), 281);

      pulse_clear();
      send("iso0", 0, 1000, 2);
      chk("iso0_val", longint'(data_o), 125);
      send("iso1", 1, -1000, 2);
      chk("iso1_val", longint'(data_o), -125);
      send("iso0_byp", 0, 1000, 1);
      send("iso1_b", 1, -1000, 2);
      chk("iso1_b_val", longint'(data_o), -250);

      // Second strobe while busy must be dropped and flag overrun.
      drive(0, 555, 1);
      valid_i = 1'b1;
      data_i  = 16'sd777;
      @(negedge clk_i);
      valid_i = 1'b0;
      chk("ovr_set", overrun_o, 1);
      collect("ovr_smp", 0, model(0, 555, 1), 2);
      send("zero", 1, 4321, 0);
      chk("ovr_sticky", overrun_o, 1);

      // Clear in READ, with a simultaneous strobe, aborts the sample.
      drive(0, 999, 2);
      clear_i = 1'b1;
      valid_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
      valid_i = 1'b0;
      model_clear();
      chk("clr_ready", ready_o, 1);
      chk("clr_ovr", overrun_o, 0);
      count_pulses(5, cnt);
      chk("clr_nopulse", cnt, 0);
      send("clr_avg", 0, 800, 2);
      chk("clr_avg_val", longint'(data_o), 100);

      // Clear wins over a strobe presented in IDLE.
      @(negedge clk_i);
      clear_i = 1'b1;
      valid_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
      valid_i = 1'b0;
      model_clear();
      count_pulses(5, cnt);
      chk("clr_prio", cnt, 0);

      for (int t = 0; t < 60; t++) begin
         int ch, d, m;
         ch = int'($urandom_range(0, CHANNELS - 1));
         d  = int'($signed(16'($urandom)));
         m  = int'($urandom_range(0, 3));
         send("rand", ch, d, m);
      end

      // Reset mid-operation zeroes outputs and aborts the sample.
      drive(1, 1234, 1);
      reset_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      chk("mrst_valid", valid_o, 0);
      chk("mrst_data", longint'(data_o), 0);
      chk("mrst_ready", ready_o, 0);
      reset_i = 1'b0;
      model_clear();
      @(negedge clk_i);
      chk("mrst_rel", ready_o, 1);
      send("mrst_iir", 1, -1600, 3);
      chk("mrst_iir_val", longint'(data_o), -100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
